adc_trigger_capture: RTL

- Sits directly downstream of the ADC deserializer. Runs in the CLKDIV domain and consumes the four parallel 14-bit channel words (adc1/adc2/adc4/adc8) plus the 8-bit frame word.
- Qualifies frame alignment, waits for a threshold trigger on one selected channel, and records a pre/post-trigger window into a circular buffer.
- Streams the captured record out over a valid/ready interface to the readout/DMA stage.

---
 rtl/adc_pkg.sv | 24 ++
 rtl/capture_ram.sv | 29 ++
 rtl/adc_trigger_capture.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/adc_pkg.sv
// Shared types and constants for the ADC trigger/capture slice.
package adc_pkg;

  localparam int ADC_W = 14;

  // Frame word the deserializer produces when its bit alignment is correct.
  localparam logic [7:0] DEFAULT_FRAME_PAT = 8'hF0;

  typedef enum logic [1:0] {
    CH_ADC1 = 2'd0,
    CH_ADC2 = 2'd1,
    CH_ADC4 = 2'd2,
    CH_ADC8 = 2'd3
  } ch_sel_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PREFILL = 3'd1,
    ARMED   = 3'd2,
    POST    = 3'd3,
    READOUT = 3'd4
  } capture_state_e;

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port.
module capture_ram
  import adc_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    wr_addr,
  input  logic [ADC_W-1:0] wr_data,
  input  logic             re,
  input  logic [AW-1:0]    rd_addr,
  output logic [ADC_W-1:0] rd_data
);

  logic [ADC_W-1:0] mem [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  // Registered read port; data appears the cycle after re.
  always_ff @(posedge clk) begin
    if (re) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/adc_trigger_capture.sv
// Frame-lock qualification, threshold trigger and pre/post-trigger capture of
// one selected ADC channel, streamed out over valid/ready.
//
// Stream handshake: a beat transfers on a rising CLKDIV edge where m_tvalid
// and m_tready are both high. Once m_tvalid rises, m_tdata/m_tlast/m_tvalid
// hold unchanged until that transfer; m_tvalid never depends on m_tready.
module adc_trigger_capture
  import adc_pkg::*;
#(
  parameter int         DEPTH     = 1024,
  parameter int         PRE_TRIG  = 64,
  parameter logic [7:0] FRAME_PAT = DEFAULT_FRAME_PAT,
  parameter int         LOCK_CNT  = 16
) (
  input  logic                   CLKDIV,
  input  logic                   cpu_resetn,
  input  logic [ADC_W-1:0]       adc1,
  input  logic [ADC_W-1:0]       adc2,
  input  logic [ADC_W-1:0]       adc4,
  input  logic [ADC_W-1:0]       adc8,
  input  logic [7:0]             frmData,
  input  logic                   arm,
  input  logic                   force_trig,
  input  logic [1:0]             ch_sel,
  input  logic [ADC_W-1:0]       threshold,
  input  logic [$clog2(DEPTH):0] post_len,
  output logic [15:0]            m_tdata,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic                   m_tlast,
  output logic                   locked,
  output logic                   busy,
  output logic                   done,
  output logic                   lock_err,
  output capture_state_e         state_dbg
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int LW = $clog2(LOCK_CNT + 1);
  localparam logic [CW-1:0] PRE_C    = CW'(PRE_TRIG);
  localparam logic [CW-1:0] MAX_POST = CW'(DEPTH - PRE_TRIG);
  localparam logic [LW-1:0] LOCK_C   = LW'(LOCK_CNT);

  capture_state_e   state, state_n;
  logic [LW-1:0]    lock_cnt;
  ch_sel_e          ch_sel_q, sel_ch;
  logic [ADC_W-1:0] thr_q, sel_sample, s0, s1;
  logic [CW-1:0]    post_len_q, post_clamp, cnt, iss_left, beats_left;
  logic [AW-1:0]    wr_ptr, trig_ptr, rd_ptr;
  logic [ADC_W-1:0] rd_data, out_d, pf_d, out_d_n, pf_d_n;
  logic             out_v, pf_v, ram_vld, out_v_n, pf_v_n;
  logic             arm_ok, abort, trig, post_done, wr_en, enter_ro;
  logic             pop, last_pop, issue;
  logic [1:0]       occ;

  assign arm_ok    = (state == IDLE) && arm && locked;
  assign abort     = !locked && ((state == PREFILL) || (state == ARMED) || (state == POST));
  assign trig      = (state == ARMED) && (((s0 < thr_q) && (s1 >= thr_q)) || force_trig);
  assign post_done = (state == POST) && (cnt == post_len_q);
  assign wr_en     = (state == PREFILL) || (state == ARMED) || ((state == POST) && !post_done);
  assign enter_ro  = (state == POST) && (state_n == READOUT);
  assign pop       = out_v && m_tready;
  assign last_pop  = pop && (beats_left == CW'(1));
  // Words held or in flight after this cycle's pop; one more read fits if <= 1.
  assign occ       = 2'(out_v) + 2'(pf_v) + 2'(ram_vld) - 2'(pop);
  assign issue     = (state == READOUT) && (iss_left != '0) && (occ <= 2'd1);

  assign busy      = (state != IDLE);
  assign state_dbg = state;
  assign m_tvalid  = out_v;
  assign m_tdata   = {2'b00, out_d};
  assign m_tlast   = out_v && (beats_left == CW'(1));

  // Lock counter saturates at LOCK_CNT; a single bad frame word drops lock.
  always_ff @(posedge CLKDIV or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      lock_cnt <= '0;
      locked   <= 1'b0;
    end else if (frmData == FRAME_PAT) begin
      if (lock_cnt != LOCK_C) lock_cnt <= lock_cnt + LW'(1);
      locked <= (lock_cnt >= LOCK_C - LW'(1));
    end else begin
      lock_cnt <= '0;
      locked   <= 1'b0;
    end
  end

  // Channel mux follows the live select in IDLE so the arm cycle already
  // samples the channel being latched; post_len is clamped to 1..DEPTH-PRE_TRIG.
  always_comb begin
    sel_ch     = (state == IDLE) ? ch_sel_e'(ch_sel) : ch_sel_q;
    sel_sample = adc1;
    unique case (sel_ch)
      CH_ADC1: sel_sample = adc1;
      CH_ADC2: sel_sample = adc2;
      CH_ADC4: sel_sample = adc4;
      CH_ADC8: sel_sample = adc8;
      default: sel_sample = adc1;
    endcase
    post_clamp = post_len;
    if (post_len == '0) post_clamp = CW'(1);
    else if (post_len > MAX_POST) post_clamp = MAX_POST;
  end

  // Output beat register plus one prefetch slot absorb the RAM read latency.
  always_comb begin
    out_v_n = out_v;
    out_d_n = out_d;
    pf_v_n  = pf_v;
    pf_d_n  = pf_d;
    if (pop) out_v_n = 1'b0;
    if (!out_v_n && pf_v_n) begin
      out_v_n = 1'b1;
      out_d_n = pf_d;
      pf_v_n  = 1'b0;
    end
    if (ram_vld) begin
      if (!out_v_n) begin
        out_v_n = 1'b1;
        out_d_n = rd_data;
      end else begin
        pf_v_n = 1'b1;
        pf_d_n = rd_data;
      end
    end
  end

  // Capture state register.
  always_ff @(posedge CLKDIV or negedge cpu_resetn) begin
    if (!cpu_resetn) state <= IDLE;
    else             state <= state_n;
  end

  // Next-state logic; lock loss before READOUT abandons the capture.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (arm_ok) state_n = (PRE_TRIG == 0) ? ARMED : PREFILL;
      PREFILL: if (abort) state_n = IDLE;
               else if ((cnt + CW'(1)) == PRE_C) state_n = ARMED;
      ARMED:   if (abort) state_n = IDLE;
               else if (trig) state_n = POST;
      POST:    if (abort) state_n = IDLE;
               else if (post_done) state_n = READOUT;
      READOUT: if (last_pop) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Sample pipeline, capture pointers/counters and readout bookkeeping.
  always_ff @(posedge CLKDIV or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      s0 <= '0; s1 <= '0;
      ch_sel_q <= CH_ADC1; thr_q <= '0; post_len_q <= '0;
      cnt <= '0; iss_left <= '0; beats_left <= '0;
      wr_ptr <= '0; trig_ptr <= '0; rd_ptr <= '0;
      ram_vld <= 1'b0; out_v <= 1'b0; pf_v <= 1'b0; out_d <= '0; pf_d <= '0;
      done <= 1'b0; lock_err <= 1'b0;
    end else begin
      s1 <= sel_sample;
      s0 <= s1;
      done <= last_pop;
      if (arm_ok) begin
        ch_sel_q   <= ch_sel_e'(ch_sel);
        thr_q      <= threshold;
        post_len_q <= post_clamp;
        lock_err   <= 1'b0;
        cnt        <= '0;
      end
      if (abort) lock_err <= 1'b1;
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (state == PREFILL) cnt <= cnt + CW'(1);
      if (trig) begin
        trig_ptr <= wr_ptr;
        cnt      <= CW'(1);
      end
      if (wr_en && (state == POST)) cnt <= cnt + CW'(1);
      if (enter_ro) begin
        rd_ptr     <= trig_ptr - AW'(PRE_TRIG);
        iss_left   <= PRE_C + post_len_q;
        beats_left <= PRE_C + post_len_q;
      end
      if (issue) begin
        rd_ptr   <= rd_ptr + AW'(1);
        iss_left <= iss_left - CW'(1);
      end
      if (pop) beats_left <= beats_left - CW'(1);
      ram_vld <= issue;
      out_v   <= out_v_n;
      out_d   <= out_d_n;
      pf_v    <= pf_v_n;
      pf_d    <= pf_d_n;
    end
  end

  capture_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk     (CLKDIV),
    .we      (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (s1),
    .re      (issue),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

endmodule
